// File: rtl/systolic_input_skewer.sv
// systolic_input_skewer: diagonal skew feeder for the 4x4 systolic array.
// Lane j delays each accepted row element by j+1 cycles; a small FSM frames tiles.
module systolic_input_skewer #(
    parameter int WIDTH    = 16,
    parameter int N        = 4,
    parameter int MAX_ROWS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_row [0:N-1],
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] out_up [0:N-1],
    output logic [N-1:0]            out_lane_valid,
    output logic                    busy,
    output logic                    tile_done
);
    localparam int RCW = $clog2(MAX_ROWS + 1);
    localparam int DCW = $clog2(N + 1);
    localparam logic [RCW-1:0] ROW_LAST   = RCW'(MAX_ROWS - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(N - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t           r_state;
    logic [RCW-1:0]   r_row_cnt;
    logic [DCW-1:0]   r_drain_cnt;
    logic             r_ready;
    logic             r_busy;
    logic             r_tile_done;
    logic             w_accept;
    logic             w_close;

    assign w_accept = in_valid && r_ready;
    // Row counter is zero in IDLE, so one compare covers both the first and the MAX_ROWS-th row.
    assign w_close  = in_last || (r_row_cnt == ROW_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_row_cnt   <= '0;
            r_drain_cnt <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_tile_done <= 1'b0;
        end else begin
            r_tile_done <= 1'b0;
            case (r_state)
                S_IDLE, S_STREAM: begin
                    if (w_accept) begin
                        r_row_cnt <= r_row_cnt + 1'b1;
                        r_busy    <= 1'b1;
                        if (w_close) begin
                            r_state     <= S_DRAIN;
                            r_ready     <= 1'b0;
                            r_drain_cnt <= '0;
                        end else begin
                            r_state <= S_STREAM;
                        end
                    end
                end
                S_DRAIN: begin
                    // Final count lines up with lane N-1 presenting the tile's last element.
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state     <= S_IDLE;
                        r_ready     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_tile_done <= 1'b1;
                        r_row_cnt   <= '0;
                        r_drain_cnt <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_ready;
    assign busy      = r_busy;
    assign tile_done = r_tile_done;

    for (genvar j = 0; j < N; j++) begin : g_lane
        logic signed [WIDTH-1:0] r_data [0:j];
        logic [j:0]              r_vld;

        // Idle cycles shift in a zero bubble, which also flushes the lane after a tile.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s <= j; s++) begin
                    r_data[s] <= '0;
                end
                r_vld <= '0;
            end else begin
                r_data[0] <= w_accept ? in_row[j] : '0;
                r_vld[0]  <= w_accept;
                for (int s = 1; s <= j; s++) begin
                    r_data[s] <= r_data[s-1];
                    r_vld[s]  <= r_vld[s-1];
                end
            end
        end

        assign out_up[j]         = r_data[j];
        assign out_lane_valid[j] = r_vld[j];
    end

endmodule

// File: tb/tb_systolic_input_skewer.sv
// tb_systolic_input_skewer: scoreboard bench for the systolic input skewer.
// Each lane has a queue of expected stage values, pushed at drive time and popped after each edge.
module tb_systolic_input_skewer;
    localparam int WIDTH    = 16;
    localparam int N        = 4;
    localparam int MAX_ROWS = 4;

    typedef enum int {M_IDLE, M_STREAM, M_DRAIN} mstate_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic signed [WIDTH-1:0] inRow [0:N-1];
    logic                    inValid;
    logic                    inLast;
    logic                    inReady;
    logic signed [WIDTH-1:0] outUp [0:N-1];
    logic [N-1:0]            outLaneValid;
    logic                    busy;
    logic                    tileDone;

    int          checkCount = 0;
    int          errorCount = 0;
    int          edgeNum    = 0;
    int          doneEdges[$];
    int          accEdges[$];
    logic [WIDTH:0] laneQ [N][$];
    mstate_t     mState;
    int          mRows;
    int          mLeft;

    systolic_input_skewer #(
        .WIDTH    (WIDTH),
        .N        (N),
        .MAX_ROWS (MAX_ROWS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_row         (inRow),
        .in_valid       (inValid),
        .in_last        (inLast),
        .in_ready       (inReady),
        .out_up         (outUp),
        .out_lane_valid (outLaneValid),
        .busy           (busy),
        .tile_done      (tileDone)
    );

    always #5 clk = ~clk;

    function automatic logic [N*WIDTH-1:0] mkRow(input int a, input int b, input int c, input int d);
        return {WIDTH'(d), WIDTH'(c), WIDTH'(b), WIDTH'(a)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h (edge %0d)", tag, observed, expected, edgeNum);
        end
    endtask

    task automatic resetModel();
        mState = M_IDLE;
        mRows  = 0;
        mLeft  = 0;
        for (int j = 0; j < N; j++) begin
            laneQ[j].delete();
            for (int s = 0; s < j; s++) begin
                laneQ[j].push_back('0);
            end
        end
    endtask

    task automatic startScenario();
        edgeNum = 0;
        doneEdges.delete();
        accEdges.delete();
    endtask

    // Called at a falling edge; drives one cycle, steps the reference model, checks after the rising edge.
    task automatic applyStimulus(input logic v, input logic l, input logic [N*WIDTH-1:0] rowBits,
                                 output logic accepted);
        logic           expDone;
        logic [WIDTH:0] ent;
        inValid = v;
        inLast  = l;
        for (int j = 0; j < N; j++) begin
            inRow[j] = rowBits[j*WIDTH +: WIDTH];
        end
        accepted = v && (mState != M_DRAIN);
        for (int j = 0; j < N; j++) begin
            laneQ[j].push_back(accepted ? {1'b1, rowBits[j*WIDTH +: WIDTH]} : '0);
        end
        expDone = 1'b0;
        case (mState)
            M_IDLE, M_STREAM: begin
                if (accepted) begin
                    mRows++;
                    if (l || mRows == MAX_ROWS) begin
                        mState = M_DRAIN;
                        mLeft  = N - 1;
                    end else begin
                        mState = M_STREAM;
                    end
                end
            end
            M_DRAIN: begin
                mLeft--;
                if (mLeft == 0) begin
                    mState  = M_IDLE;
                    mRows   = 0;
                    expDone = 1'b1;
                end
            end
            default: mState = M_IDLE;
        endcase
        @(posedge clk);
        #1;
        for (int j = 0; j < N; j++) begin
            ent = laneQ[j].pop_front();
            checkOutput($sformatf("lane%0d_data", j), $unsigned(outUp[j]), ent[WIDTH-1:0]);
            checkOutput($sformatf("lane%0d_valid", j), outLaneValid[j], ent[WIDTH]);
        end
        checkOutput("in_ready", inReady, mState != M_DRAIN);
        checkOutput("busy", busy, mState != M_IDLE);
        checkOutput("tile_done", tileDone, expDone);
        if (tileDone) doneEdges.push_back(edgeNum);
        edgeNum++;
        @(negedge clk);
    endtask

    task automatic runFullTile(input string pfx);
        logic             acc;
        logic [N*WIDTH-1:0] tab [7];
        tab[0] = mkRow(1, 0, 0, 0);
        tab[1] = mkRow(5, 2, 0, 0);
        tab[2] = mkRow(9, 6, 3, 0);
        tab[3] = mkRow(13, 10, 7, 4);
        tab[4] = mkRow(0, 14, 11, 8);
        tab[5] = mkRow(0, 0, 15, 12);
        tab[6] = mkRow(0, 0, 0, 16);
        startScenario();
        for (int e = 0; e < 8; e++) begin
            if (e < 4) applyStimulus(1'b1, e == 3, mkRow(4*e+1, 4*e+2, 4*e+3, 4*e+4), acc);
            else       applyStimulus(1'b0, 1'b0, '0, acc);
            if (e < 7) begin
                for (int j = 0; j < N; j++) begin
                    checkOutput($sformatf("%s_tab_e%0d_l%0d", pfx, e, j), $unsigned(outUp[j]),
                                32'(tab[e][j*WIDTH +: WIDTH]));
                end
                checkOutput($sformatf("%s_ready_e%0d", pfx, e), inReady, !(e >= 3 && e <= 5));
                checkOutput($sformatf("%s_done_e%0d", pfx, e), tileDone, e == 6);
            end
        end
        checkOutput({pfx, "_done_count"}, doneEdges.size(), 1);
        checkOutput({pfx, "_done_edge"}, (doneEdges.size() > 0) ? doneEdges[0] : -1, 6);
    endtask

    task automatic streamRows(input int nRows, input logic [15:0] lastMask, input int base);
        logic acc;
        int   p;
        int   eNow;
        p = 0;
        for (int c = 0; c < 60 && p < nRows; c++) begin
            eNow = edgeNum;
            applyStimulus(1'b1, lastMask[p], mkRow(base+4*p+1, base+4*p+2, base+4*p+3, base+4*p+4), acc);
            if (acc) begin
                accEdges.push_back(eNow);
                p++;
            end
        end
        checkOutput("stream_all_accepted", p, nRows);
        for (int c = 0; c < N + 1; c++) begin
            applyStimulus(1'b0, 1'b0, '0, acc);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acc;
        inValid = 1'b0;
        inLast  = 1'b0;
        for (int j = 0; j < N; j++) inRow[j] = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", inReady, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", tileDone, 0);
        checkOutput("reset_lane_valid", outLaneValid, 0);
        for (int j = 0; j < N; j++) checkOutput($sformatf("reset_out%0d", j), $unsigned(outUp[j]), 0);
        rst = 1'b1;
        resetModel();

        runFullTile("s1");

        // Bubble between rows 2 and 3 delays completion by one cycle.
        startScenario();
        for (int e = 0; e < 10; e++) begin
            case (e)
                0: applyStimulus(1'b1, 1'b0, mkRow(1, 2, 3, 4), acc);
                1: applyStimulus(1'b1, 1'b0, mkRow(5, 6, 7, 8), acc);
                3: applyStimulus(1'b1, 1'b0, mkRow(9, 10, 11, 12), acc);
                4: applyStimulus(1'b1, 1'b1, mkRow(13, 14, 15, 16), acc);
                default: applyStimulus(1'b0, 1'b0, '0, acc);
            endcase
            if (e >= 2 && e <= 5) checkOutput($sformatf("s2_bubble_l%0d", e-2), outLaneValid[e-2], 0);
        end
        checkOutput("s2_done_edge", (doneEdges.size() > 0) ? doneEdges[0] : -1, 7);

        // Implicit close at MAX_ROWS; the fifth row waits for the drain.
        startScenario();
        streamRows(5, 16'b1_0000, 100);
        checkOutput("s3_done_edge", (doneEdges.size() > 0) ? doneEdges[0] : -1, 6);
        checkOutput("s3_row4_edge", (accEdges.size() > 3) ? accEdges[3] : -1, 3);
        checkOutput("s3_row5_edge", (accEdges.size() > 4) ? accEdges[4] : -1, 7);
        checkOutput("s3_done2_edge", (doneEdges.size() > 1) ? doneEdges[1] : -1, 10);

        // Single negative row: sign preserved on every lane.
        startScenario();
        for (int e = 0; e < 6; e++) begin
            applyStimulus(e == 0, e == 0, (e == 0) ? mkRow(-1, -2, -3, -4) : '0, acc);
            if (e < N) checkOutput($sformatf("s4_lane%0d_sign", e), $unsigned(outUp[e]), 32'h0000FFFF - e);
        end
        checkOutput("s4_done_edge", (doneEdges.size() > 0) ? doneEdges[0] : -1, 3);

        // Reset asserted while draining discards the tile.
        startScenario();
        for (int e = 0; e < 5; e++) begin
            if (e < 4) applyStimulus(1'b1, e == 3, mkRow(4*e+1, 4*e+2, 4*e+3, 4*e+4), acc);
            else       applyStimulus(1'b0, 1'b0, '0, acc);
        end
        checkOutput("s5_in_drain", inReady, 0);
        rst = 1'b0;
        #1;
        checkOutput("s5_rst_ready", inReady, 1);
        checkOutput("s5_rst_busy", busy, 0);
        checkOutput("s5_rst_done", tileDone, 0);
        checkOutput("s5_rst_lane_valid", outLaneValid, 0);
        for (int j = 0; j < N; j++) checkOutput($sformatf("s5_rst_out%0d", j), $unsigned(outUp[j]), 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("s5_rst_hold_done%0d", c), tileDone, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        resetModel();
        runFullTile("s5post");

        // Back-to-back tiles with in_valid held high.
        startScenario();
        streamRows(8, 16'b1000_1000, 200);
        checkOutput("s6_done1_edge", (doneEdges.size() > 0) ? doneEdges[0] : -1, 6);
        checkOutput("s6_tile2_start", (accEdges.size() > 4) ? accEdges[4] : -1,
                    (doneEdges.size() > 0) ? doneEdges[0] + 1 : -2);
        checkOutput("s6_tile2_start_abs", (accEdges.size() > 4) ? accEdges[4] : -1, 7);
        checkOutput("s6_done2_edge", (doneEdges.size() > 1) ? doneEdges[1] : -1, 13);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/systolic_input_skewer.md
# systolic_input_skewer

Upstream feeder for the 4x4 systolic array top (`main`). It accepts one matrix row per cycle over a valid/ready handshake and drives the array's `in_up` lanes with the diagonal skew the array requires: element j of row r reaches lane j at cycle r+j. Lanes with no data are driven with zero padding. After the last row of a tile it flushes its delay lines and signals tile completion, so the array's `in_up` ports can be driven directly from `out_up`.

## Interface
- `WIDTH`, 16, signed element width.
- `N`, 4, number of lanes; equals the array dimension.
- `MAX_ROWS`, 4, maximum rows per tile; a tile is forced to close when this count is reached.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_row[0:N-1]`  in  WIDTH each, signed  row elements; element j goes to lane j.
- `in_valid`  in  1  row present.
- `in_last`  in  1  row is the final row of the tile; qualified by `in_valid`.
- `in_ready`  out  1  skewer can accept a row this cycle.
- `out_up[0:N-1]`  out  WIDTH each, signed  skewed lanes; connect to the array's `in_up`.
- `out_lane_valid[N-1:0]`  out  N  bit j is high when `out_up[j]` carries a real element.
- `busy`  out  1  a tile is in progress (STREAM or DRAIN).
- `tile_done`  out  1  one-cycle pulse when the last element of the tile leaves lane N-1.

## Operation
- Lane j is a delay line of j+1 registers, each holding a WIDTH data bit-field plus a valid bit. `out_up[j]` and `out_lane_valid[j]` come directly from the final stage, so all outputs are registered.
- A row is accepted when `in_valid && in_ready` at a rising edge. On accept, stage 0 of every lane loads `in_row[j]` with valid=1.
- When no row is accepted, stage 0 loads 0 with valid=0. This zero bubble holds even in the middle of a tile, so a gap in `in_valid` inserts an all-zero row into the stream.
- All stages shift every cycle. There is no stall path; the array downstream never back-pressures.
- FSM states:
  - IDLE: `in_ready`=1 and `busy`=0. An accepted row moves to STREAM, or straight to DRAIN if `in_last` is set or `MAX_ROWS`=1.
  - STREAM: `in_ready`=1. Each accepted row increments `row_cnt`. The FSM moves to DRAIN on an accept where `in_last`=1, or where the accepted row is number `MAX_ROWS` (implicit last).
  - DRAIN: `in_ready`=0. `drain_cnt` counts N-1 cycles. On the final count the FSM returns to IDLE and `tile_done` pulses.
- `row_cnt` is $clog2(`MAX_ROWS`+1) bits and clears on entry to IDLE. `in_last` outside an accept is ignored.
- No arithmetic is performed; data passes unchanged and signed.

## Timing
- Reset value (async, `rst`=0): every stage data=0 and valid=0; `out_up`=0, `out_lane_valid`=0, `in_ready`=1, `busy`=0, `tile_done`=0; FSM in IDLE with both counters at 0.
- Release of `rst` is synchronous to `clk` in effect; the first accept can occur at the first rising edge with `rst`=1.
- Latency: a row accepted at edge k appears on lane j after edge k+j, i.e. lane 0 has 1-cycle latency and lane N-1 has N-cycle latency.
- Last row accepted at edge k:
  - `in_ready` is low for the cycles after edges k..k+N-2.
  - `tile_done` and `busy`=0 appear in the cycle after edge k+N-1, coinciding with lane N-1 presenting the final element.
  - `in_ready` returns high in that same cycle, so the next tile's first row can be accepted at edge k+N with no overlap of tiles on any lane.
- Reset asserted mid-tile: the tile is discarded immediately; no `tile_done` pulse.
- `in_last` together with row `MAX_ROWS`: a single close, not a double close.

## Test plan
- Rows [1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16] are accepted at edges 0-3, with `in_last` on the fourth row. Required `out_up` after edges 0..6: [1,0,0,0], [5,2,0,0], [9,6,3,0], [13,10,7,4], [0,14,11,8], [0,0,15,12], [0,0,0,16]. `tile_done`=1 only after edge 6; `in_ready`=0 only after edges 3-5.
- Same tile with `in_valid`=0 for one cycle between rows 2 and 3. The bubble must appear as a zero diagonal with the matching `out_lane_valid` bits low, and `tile_done` must move one cycle later (after edge 7).
- Four rows are sent with `in_last` never asserted. The implicit close on row 4 must give timing identical to the first scenario; a fifth `in_valid` is held off (`in_ready`=0) until `tile_done`.
- Single row [-1,-2,-3,-4] with `in_last`. Lane j must show the value after edge j, sign preserved (0xFFFF for -1 at WIDTH=16); `tile_done` after edge 3.
- `rst` pulled low during DRAIN. All outputs must go to 0 and `in_ready` to 1 immediately with no `tile_done`; the next tile must then run cleanly.
- Back-to-back tiles with `in_valid` held high. The second tile's first row must be accepted exactly at the edge after `tile_done` is asserted, with no lane carrying elements of both tiles in the same cycle.
